// File: rtl/n64rgb_pkg.sv
// Shared encodings for the N64 RGB de-blur estimator.
// Bus phases, sync bit positions, gradient codes, filter defaults.
package n64rgb_pkg;

  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_R    = 2'b01,
    PH_G    = 2'b10,
    PH_B    = 2'b11
  } phase_e;

  localparam int VSYNC_BIT = 3;
  localparam int CSYNC_BIT = 0;

  typedef struct packed {
    logic nvsync;
    logic ncsync;
  } sync_t;

  localparam logic [1:0] GR_FLAT = 2'b00;
  localparam logic [1:0] GR_DOWN = 2'b01;
  localparam logic [1:0] GR_UP   = 2'b10;
  localparam logic [1:0] GR_REV  = 2'b11;

  localparam int DEF_TREND_W = 9;
  localparam int DEF_HYST    = 16;

endpackage

// File: rtl/n64_deblur_estimator_if.sv
// Multiplexed N64 video bus: sync/colour words plus phase.
// The console side drives, the estimator listens.
interface n64_deblur_estimator_if #(
  parameter int COLOR_W = 7
);
  logic               nDSYNC;
  logic [COLOR_W-1:0] D_i;
  logic [1:0]         data_cnt;

  modport master (output nDSYNC, D_i, data_cnt);
  modport slave  (input  nDSYNC, D_i, data_cnt);
endinterface

// File: rtl/n64_trend_filter.sv
// Saturating up/down trend counter with a hysteresis
// decision around the midpoint.
module n64_trend_filter
  import n64rgb_pkg::*;
#(
  parameter int TREND_W = DEF_TREND_W,
  parameter int HYST    = DEF_HYST
) (
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               vote_en_i,
  input  logic               vote_i,
  output logic [TREND_W-1:0] trend_o,
  output logic               nblur_o
);

  localparam int MID = 2 ** (TREND_W - 1);
  localparam logic [TREND_W-1:0] MID_V = TREND_W'(MID);
  localparam logic [TREND_W-1:0] HI_TH = TREND_W'(MID + HYST);
  localparam logic [TREND_W-1:0] LO_TH = TREND_W'(MID - HYST);
  localparam logic [TREND_W-1:0] MAX_V = {TREND_W{1'b1}};

  logic [TREND_W-1:0] trend_q, trend_d;
  logic               nblur_q, nblur_d;

  // step the trend on a vote and re-evaluate the hysteresis band
  always_comb begin
    trend_d = trend_q;
    nblur_d = nblur_q;
    if (vote_en_i) begin
      if (vote_i) begin
        if (trend_q != MAX_V) trend_d = trend_q + 1'b1;
      end else begin
        if (trend_q != '0) trend_d = trend_q - 1'b1;
      end
      if (trend_d >= HI_TH)
        nblur_d = 1'b1;
      else if (trend_d < LO_TH)
        nblur_d = 1'b0;
    end
  end

  // filter state; reset parks at the midpoint, blur off
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      trend_q <= MID_V;
      nblur_q <= 1'b1;
    end else begin
      trend_q <= trend_d;
      nblur_q <= nblur_d;
    end
  end

  assign trend_o = trend_q;
  assign nblur_o = nblur_q;

endmodule

// File: rtl/n64_deblur_estimator.sv
// Per-frame estimate of console blur from gradient reversals,
// driving the frame-synchronous de-blur decision.
module n64_deblur_estimator
  import n64rgb_pkg::*;
#(
  parameter int COLOR_W  = 7,
  parameter int CMP_BITS = 3,
  parameter int TREND_W  = DEF_TREND_W,
  parameter int HYST     = DEF_HYST,
  parameter int MIN_HITS = 3
) (
  input  logic                 VCLK,
  input  logic                 nRST,
  n64_deblur_estimator_if.slave bus,
  input  logic                 vmode,
  input  logic                 n64_480i,
  input  logic                 nForceDeBlur,
  input  logic                 nDeBlurMan,
  output logic                 ndo_deblur,
  output logic                 nblur_est,
  output logic [TREND_W-1:0]   trend_o,
  output logic                 est_valid
);

  localparam int HIT_W =
    (MIN_HITS < 2) ? 1 : $clog2(MIN_HITS + 1);
  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(MIN_HITS);

  logic                         sync_word;
  logic                         neg_vsync;
  logic                         pos_csync;
  logic [CMP_BITS-1:0]          px;
  logic [2:0]                   cap;
  logic [2:0][1:0]              grad;
  sync_t                        sync_prev_q, sync_prev_d;
  logic                         blur_q, blur_d;
  logic [2:0][CMP_BITS-1:0]     cur_q, cur_d;
  logic [2:0][1:0]              gst_q, gst_d;
  logic [2:0]                   flag_q, flag_d;
  logic [HIT_W-1:0]             hit_q, hit_d;
  logic                         est_q, est_d;
  logic                         ndo_q, ndo_d;
  logic                         vote_en;
  logic                         vote;
  logic                         nblur;
  logic                         unused_d;

  assign sync_word = ~bus.nDSYNC;
  assign px = bus.D_i[COLOR_W-1 -: CMP_BITS];
  assign neg_vsync = sync_word & sync_prev_q.nvsync
                   & ~bus.D_i[VSYNC_BIT];
  assign pos_csync = sync_word & ~sync_prev_q.ncsync
                   & bus.D_i[CSYNC_BIT];
  assign unused_d = ^bus.D_i;

  // decode which channel register the current word belongs to
  always_comb begin
    cap = 3'b000;
    if (bus.nDSYNC) begin
      unique case (phase_e'(bus.data_cnt))
        PH_R:    cap = 3'b001;
        PH_G:    cap = 3'b010;
        PH_B:    cap = 3'b100;
        default: cap = 3'b000;
      endcase
    end
  end

  // each channel compared only against its own previous pixel
  always_comb begin
    for (int c = 0; c < 3; c++)
      grad[c] = {cur_q[c] < px, cur_q[c] > px};
  end

  // pixel capture, reversal flags, hit count, frame decisions
  always_comb begin
    sync_prev_d = sync_prev_q;
    blur_d      = blur_q;
    cur_d       = cur_q;
    gst_d       = gst_q;
    flag_d      = flag_q;
    hit_d       = hit_q;
    est_d       = est_q;
    ndo_d       = ndo_q;
    for (int c = 0; c < 3; c++) begin
      if (cap[c]) begin
        cur_d[c] = px;
        if (blur_q)
          gst_d[c] = grad[c];
        else
          flag_d[c] = ((gst_q[c] ^ grad[c]) == GR_REV);
      end
    end
    if (sync_word) begin
      sync_prev_d = {bus.D_i[VSYNC_BIT], bus.D_i[CSYNC_BIT]};
      blur_d = pos_csync ? ~vmode : ~blur_q;
      flag_d = '0;
      if (!blur_q && (&flag_q) && hit_q < HIT_MAX)
        hit_d = hit_q + 1'b1;
    end
    // frame edge wins over a hit landing on the same word
    if (neg_vsync) begin
      hit_d = '0;
      ndo_d = n64_480i
            | (nForceDeBlur ? nblur : nDeBlurMan);
      if (!n64_480i) est_d = 1'b1;
    end
    if (n64_480i) est_d = 1'b0;
  end

  // estimator state registers
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      sync_prev_q <= '{nvsync: 1'b1, ncsync: 1'b1};
      blur_q      <= 1'b0;
      cur_q       <= '0;
      gst_q       <= '0;
      flag_q      <= '0;
      hit_q       <= '0;
      est_q       <= 1'b0;
      ndo_q       <= 1'b1;
    end else begin
      sync_prev_q <= sync_prev_d;
      blur_q      <= blur_d;
      cur_q       <= cur_d;
      gst_q       <= gst_d;
      flag_q      <= flag_d;
      hit_q       <= hit_d;
      est_q       <= est_d;
      ndo_q       <= ndo_d;
    end
  end

  assign vote_en = neg_vsync & ~n64_480i & est_q;
  assign vote    = (hit_q >= HIT_MAX);

  n64_trend_filter #(
    .TREND_W (TREND_W),
    .HYST    (HYST)
  ) u_trend (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .vote_en_i (vote_en),
    .vote_i    (vote),
    .trend_o   (trend_o),
    .nblur_o   (nblur)
  );

  assign nblur_est  = nblur;
  assign ndo_deblur = ndo_q;
  assign est_valid  = est_q;

endmodule
